uart_rx_sample_ctrl: RTL

UART_RX_SAMPLE_CTRL -- requirements
Module: uart_rx_sample_ctrl

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx_sample_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sample controller.
// Holds the controller state encoding, the default oversampling ratio and the
// helper that derives the mid-bit tick index from the oversampling ratio.
package uart_rx_pkg;

    // Default number of baud_tick pulses per serial bit period.
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_CHK = 2'd1,
        RUN       = 2'd2,
        WAIT_HIGH = 2'd3
    } rx_state_e;

    // Tick index closest to the centre of a bit period (counter starts at 0).
    function automatic int calc_mid(input int oversample);
        return (oversample / 2) - 1;
    endfunction

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input.
// Both stages reset to 1 so an idle (high) line is seen during and right after
// reset and no spurious start edge is produced.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Each stage simply takes the value of the previous one.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops with synchronous reset to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx_sample_ctrl.sv
// UART receive sample controller.
// Detects and validates start bits on an oversampled serial line, then emits
// one registered bit_valid pulse per bit at the bit centre until the external
// RX state machine ends the frame. After a frame it waits for the line to
// return high so a break or stuck-low line cannot retrigger reception.
//
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3
// majority of the samples at ticks MID-1, MID and MID+1. The decision is then
// taken on the MID+1 tick, so every pulse appears one baud tick later.
module uart_rx_sample_ctrl
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic baud_tick,
    input  logic rx_in,
    input  logic frame_active,
    input  logic frame_complete,
    output logic bit_valid,
    output logic bit_sample,
    output logic start_detected,
    output logic false_start,
    output logic busy
);

    // OVERSAMPLE is expected to be even and at least 8, which keeps MID-1 and
    // MID+1 inside the counter range.
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(calc_mid(OVERSAMPLE));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] LO_CNT     = CNT_W'(calc_mid(OVERSAMPLE) - 1);
    localparam logic [CNT_W-1:0] DECIDE_CNT = CNT_W'(calc_mid(OVERSAMPLE) + 1);
`else
    localparam logic [CNT_W-1:0] DECIDE_CNT = MID_CNT;
`endif

    rx_state_e        state_q;
    rx_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             bit_valid_q;
    logic             bit_valid_d;
    logic             bit_sample_q;
    logic             bit_sample_d;
    logic             start_detected_q;
    logic             start_detected_d;
    logic             false_start_q;
    logic             false_start_d;
    logic             rx_s;
    logic             at_decide;
    logic             sample_val;
    logic             counting;

`ifdef UART_RX_MAJORITY_EN
    logic cap_lo_q;
    logic cap_lo_d;
    logic cap_mid_q;
    logic cap_mid_d;
`endif

    // The raw line is never used before it has been through the synchronizer.
    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    // Decision point, counter increment and the bit value seen at that point.
    always_comb begin
        counting  = (state_q == START_CHK) || (state_q == RUN);
        at_decide = baud_tick && (cnt_q == DECIDE_CNT);
        cnt_inc   = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
`ifdef UART_RX_MAJORITY_EN
        sample_val = (cap_lo_q & cap_mid_q) | (cap_lo_q & rx_s) | (cap_mid_q & rx_s);
`else
        sample_val = rx_s;
`endif
    end

    // Next-state logic; dropping enable forces IDLE ahead of everything else.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (baud_tick && !rx_s) begin
                        state_d = START_CHK;
                    end
                end
                START_CHK: begin
                    if (at_decide) begin
                        state_d = sample_val ? IDLE : RUN;
                    end
                end
                RUN: begin
                    if (frame_complete || (at_decide && !frame_active)) begin
                        state_d = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (baud_tick && rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Tick counter: free-runs across START_CHK and RUN so that the first RUN
    // decision lands exactly one bit period after the start-bit decision.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || !counting) begin
            cnt_d = '0;
        end else if (baud_tick) begin
            cnt_d = cnt_inc;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Capture the synchronized line on the two ticks before the decision tick.
    always_comb begin
        cap_lo_d  = cap_lo_q;
        cap_mid_d = cap_mid_q;
        if (counting && baud_tick) begin
            if (cnt_q == LO_CNT) begin
                cap_lo_d = rx_s;
            end
            if (cnt_q == MID_CNT) begin
                cap_mid_d = rx_s;
            end
        end
    end
`endif

    // Output pulses and held sample value; a frame exit suppresses the pulse.
    always_comb begin
        bit_valid_d      = 1'b0;
        start_detected_d = 1'b0;
        false_start_d    = 1'b0;
        bit_sample_d     = bit_sample_q;
        if (!enable) begin
            bit_sample_d = 1'b1;
        end else begin
            case (state_q)
                START_CHK: begin
                    if (at_decide) begin
                        if (!sample_val) begin
                            start_detected_d = 1'b1;
                            bit_valid_d      = 1'b1;
                            bit_sample_d     = 1'b0;
                        end else begin
                            false_start_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (at_decide && !frame_complete && frame_active) begin
                        bit_valid_d  = 1'b1;
                        bit_sample_d = sample_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            bit_valid_q      <= 1'b0;
            bit_sample_q     <= 1'b1;
            start_detected_q <= 1'b0;
            false_start_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            bit_valid_q      <= bit_valid_d;
            bit_sample_q     <= bit_sample_d;
            start_detected_q <= start_detected_d;
            false_start_q    <= false_start_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Majority capture registers, reset to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_lo_q  <= 1'b1;
            cap_mid_q <= 1'b1;
        end else begin
            cap_lo_q  <= cap_lo_d;
            cap_mid_q <= cap_mid_d;
        end
    end
`endif

    assign bit_valid      = bit_valid_q;
    assign bit_sample     = bit_sample_q;
    assign start_detected = start_detected_q;
    assign false_start    = false_start_q;
    assign busy           = (state_q != IDLE);

endmodule : uart_rx_sample_ctrl
